alu_seq_pipe: RTL

//  Parametrised, registered successor of the RNBIP-2 8-bit combinational ALU.
//  - Same 16 legacy opcodes, generalised to WIDTH bits.
//  - Adds valid/ready handshakes on input and output, a held flag register and carry-flag chaining.
//  - Adds an optional iterative multiplier.
//  - Sits between the register file / OR2 path and the accumulator write-back in the datapath.

---
 rtl/alu_seq_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_pipe.sv
// alu_seq_pipe: registered WIDTH-bit ALU with valid/ready handshakes, held flags and carry chaining.
// Build option: define ALU_SEQ_MUL_EN to add the iterative shift-add multiplier on op 5'h10.

module alu_seq_pipe #(
    parameter int unsigned WIDTH    = 8,
    parameter logic [3:0]  FLAG_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic             sel_a,
    input  logic             sel_b,
    input  logic             use_cf,
    input  logic             cin_ext,
    input  logic [WIDTH-1:0] r0_in,
    input  logic [WIDTH-1:0] rn_in,
    input  logic [WIDTH-1:0] or2_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal_op
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_cin;
    logic             accept;
    logic             is_mul;
    logic             is_illegal;
    logic             mul_last;
    logic [WIDTH:0]   alu_wide;

    // Legacy opcode table evaluated at WIDTH+1 bits; bit WIDTH is the carry/borrow.
    function automatic logic [WIDTH:0] legacy_alu(input logic [3:0]       code,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             cin);
        logic [WIDTH:0] wa, wb, wc, r;
        wa = {1'b0, a};
        wb = {1'b0, b};
        wc = {{WIDTH{1'b0}}, cin};
        r  = '0;
        case (code)
            4'h0: r = '0;
            4'h1: r = wa;
            4'h2: r = {1'b0, ~a};
            4'h3: r = wb;
            4'h4: r = wa + ONE_W;
            4'h5: r = wa - ONE_W;
            4'h6: r = {a, cin};
            4'h7: r = {a[0], cin, a[WIDTH-1:1]};
            4'h8: r = wa + wb;
            4'h9: r = wb - wa;
            4'hA: r = wa + wb + wc;
            4'hB: r = wb - wa - wc;
            4'hC: r = {1'b0, a & b};
            4'hD: r = {1'b0, a | b};
            4'hE: r = {1'b0, a ^ b};
            4'hF: r = {1'b0, ~(a ^ b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r, input logic c);
        return {^r, ~r[WIDTH-1], c, ~|r};
    endfunction

    assign op_a   = sel_a  ? rn_in    : r0_in;
    assign op_b   = sel_b  ? or2_in   : rn_in;
    // Chaining reads the registered flags, i.e. those of the last completed op.
    assign op_cin = use_cf ? flags[1] : cin_ext;

`ifdef ALU_SEQ_MUL_EN
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mul_a_q, mul_hi_q, mul_lo_q;
    logic [CNT_W-1:0] mul_cnt_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next, mul_lo_next;

    assign is_mul      = (op == 5'h10);
    assign mul_sum     = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, mul_a_q} : '0);
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], mul_lo_q[WIDTH-1:1]};
    assign mul_last    = (mul_cnt_q == CNT_W'(WIDTH - 1));

    // Shift-add: the multiplier sits in the low half and is consumed one bit per step
    // while partial sums shift in from the top.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_a_q   <= '0;
            mul_hi_q  <= '0;
            mul_lo_q  <= '0;
            mul_cnt_q <= '0;
        end else if (accept && is_mul) begin
            mul_a_q   <= op_a;
            mul_hi_q  <= '0;
            mul_lo_q  <= op_b;
            mul_cnt_q <= '0;
        end else if (state_q == S_EXEC) begin
            mul_hi_q  <= mul_hi_next;
            mul_lo_q  <= mul_lo_next;
            mul_cnt_q <= mul_cnt_q + CNT_W'(1);
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_last = 1'b1;
`endif

    assign is_illegal = op[4] & ~is_mul;
    assign alu_wide   = op[4] ? '0 : legacy_alu(op[3:0], op_a, op_b, op_cin);
    assign accept     = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples
            // pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = is_mul ? S_EXEC : S_DONE;
            end
            S_EXEC: begin
                if (mul_last) state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) state_d = is_mul ? S_EXEC : S_DONE;
                    else          state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result, flags and illegal_op only change when an op completes, so they hold in DONE
    // under backpressure and the flags stay visible for chaining while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result     <= '0;
            flags      <= FLAG_RST;
            illegal_op <= 1'b0;
        end else if (accept && !is_mul) begin
            result     <= alu_wide[WIDTH-1:0];
            flags      <= make_flags(alu_wide[WIDTH-1:0], alu_wide[WIDTH]);
            illegal_op <= is_illegal;
        end
`ifdef ALU_SEQ_MUL_EN
        else if (state_q == S_EXEC && mul_last) begin
            result     <= mul_lo_next;
            flags      <= make_flags(mul_lo_next, |mul_hi_next);
            illegal_op <= 1'b0;
        end
`endif
    end

endmodule
